max_pool_2x2: RTL and testbench
===============================

# max_pool_2x2

Streaming 2x2 max-pooling stage that sits directly upstream of `dense_layer1`. It accepts a 28x28 signed 16-bit image one pixel per cycle in raster order, reduces each non-overlapping 2x2 window to its maximum, and assembles the 196-entry (14x14) `pooled_img` array that `dense_layer1` consumes. It raises `pool_done` once the full array is valid; the integration drives `dense_layer1.enable` from `pool_done`.

## Interface
- `IMG_W`, 28: input image width and height (square, even).
- `DATA_W`, 16: signed pixel width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable`  in  1  stage enable. While low, no pixels are accepted and all state holds.
- `pix_in`  in  DATA_W signed  current pixel.
- `pix_valid`  in  1  `pix_in` is valid this cycle.
- `pooled_img`  out  DATA_W signed x (IMG_W/2)^2, indexed [0:195]  pooled map, row-major, index = i*14+j.
- `pool_done`  out  1  high while `pooled_img` holds a complete frame.

## Operation
- Accept condition: `enable && pix_valid` at a rising edge. No backpressure: every accepted pixel is consumed.
- Counters: `col` 0..27 and `row` 0..27. On each accept, `col` increments. At col=27, `col` wraps to 0 and `row` increments. At (27,27), both wrap to 0.
- `left` register holds the pixel accepted at an even col.
- Even row, odd col: `row_buf[col/2] <= max(left, pix_in)`. `row_buf` is 14 entries.
- Odd row, odd col: `pooled_img[(row/2)*14 + col/2] <= max(row_buf[col/2], left, pix_in)`.
- Comparisons are signed, full DATA_W, with no saturation or ReLU. Ties are irrelevant because the value is identical.
- FSM states:
  - IDLE: reset state, `pool_done`=0. The first accept moves to FILL.
  - FILL: accepting pixels. The accept of (27,27) moves to DONE.
  - DONE: `pool_done`=1 and `pooled_img` is stable. The next accept is pixel (0,0) of a new frame, which moves to FILL and clears `pool_done`.
- `pooled_img` entries are overwritten progressively during a new frame. The consumer must sample them before its first odd-row/odd-col pixel, which arrives 29 accepts into the frame.

## Timing
- Reset (reset=0, asynchronous) clears the following, regardless of state or mid-frame progress:
  - `pooled_img` all 0
  - `row_buf` 0
  - `left` 0
  - `row` 0, `col` 0
  - state IDLE
  - `pool_done` 0
- After reset deasserts, the first accepted pixel is (0,0).
- Write latency: `pooled_img[k]` is updated at the edge that accepts pixel (2i+1, 2j+1) and is visible the following cycle.
- `pool_done` rises at the same edge as the write of `pooled_img[195]`, so both are visible together one cycle after the final accept.
- Minimum frame time is 784 cycles. Stalls (`pix_valid`=0 or `enable`=0) extend it and do not alter results.
- `pool_done` falls at the edge that accepts the first pixel of the next frame.
- Simultaneous `enable`=0 and `pix_valid`=1: the pixel is ignored and state holds.
- Reset asserted concurrently with an accept: reset wins and the pixel is discarded.

## Test plan
- **All-zero frame:** 784 accepts of 0. Required response: `pool_done`=1 exactly one cycle after the last accept, and all 196 outputs are 0.
- **Ramp frame:** pixel = row*28+col. Required response: `pooled_img[i*14+j]` = (2i+1)*28 + 2j+1, so [0]=29, [13]=55, [195]=783.
- **Negative values:** all pixels -5 except (0,1) = -1 and (27,26) = -3. Required response: [0]=-1, [195]=-3, all others -5.
- **Stalls:**
  - Ramp frame with `pix_valid` low on every third cycle, plus a 50-cycle `enable`=0 gap mid-frame while `pix_valid`=1. Required response: results identical to the ramp test.
  - `pool_done` stays 0 until the last accept.
- **Reset mid-frame:** assert reset=0 after 300 accepts. Required response: all outputs are 0 immediately, without waiting for a clock edge. Then deassert and send a full ramp frame: results are correct.
- **Back-to-back frames:** a ramp frame followed immediately by an all-7 frame.
  - `pool_done` falls the cycle after the first accept of frame 2.
  - `pooled_img[0]` holds 29 until 29 accepts into frame 2, then reads 7.
  - `pool_done` re-asserts after 784 accepts, with all outputs 7.

Source files
------------

// File: rtl/max_pool_2x2_if.sv
// Pixel-stream and pooled-map bundle for the 2x2 max-pooling stage.
// The master drives the pixel stream; the slave (pooling stage) returns the
// pooled map and its completion flag.
interface max_pool_2x2_if #(
    parameter int IMG_W  = 28,
    parameter int DATA_W = 16
);
    localparam int OUT_N = (IMG_W / 2) * (IMG_W / 2);

    logic                     enable;
    logic                     pix_valid;
    logic signed [DATA_W-1:0] pix_in;
    logic signed [DATA_W-1:0] pooled_img [0:OUT_N-1];
    logic                     pool_done;

    modport master (
        output enable,
        output pix_valid,
        output pix_in,
        input  pooled_img,
        input  pool_done
    );

    modport slave (
        input  enable,
        input  pix_valid,
        input  pix_in,
        output pooled_img,
        output pool_done
    );
endinterface

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 max-pooling stage. Pixels arrive one per accept in raster
// order; each non-overlapping 2x2 window is reduced to its signed maximum and
// written into a row-major (IMG_W/2)^2 output map. pool_done is high while the
// map holds a complete frame.
module max_pool_2x2 #(
    parameter int IMG_W  = 28,
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset,   // asynchronous, active-low
    max_pool_2x2_if.slave  bus
);
    localparam int HALF   = IMG_W / 2;
    localparam int OUT_N  = HALF * HALF;
    localparam int CNT_W  = $clog2(IMG_W);
    localparam int HALF_W = $clog2(HALF);
    localparam int IDX_W  = $clog2(OUT_N);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CNT_W-1:0]         col_q, col_d;
    logic [CNT_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] left_q, left_d;
    logic signed [DATA_W-1:0] row_buf_q [0:HALF-1];
    logic signed [DATA_W-1:0] row_buf_d [0:HALF-1];
    logic signed [DATA_W-1:0] pooled_q  [0:OUT_N-1];
    logic signed [DATA_W-1:0] pooled_d  [0:OUT_N-1];
    state_t                   state_q, state_d;
    logic                     pool_done_q, pool_done_d;

    logic                     accept;
    logic                     last_col;
    logic                     last_row;
    logic [HALF_W-1:0]        half_col;
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W-1:0] pool_val;
    logic [IDX_W-1:0]         pool_idx;
    logic                     rb_wr;
    logic                     pool_wr;

    assign accept   = bus.enable && bus.pix_valid;
    assign last_col = (col_q == CNT_W'(IMG_W - 1));
    assign last_row = (row_q == CNT_W'(IMG_W - 1));
    assign half_col = HALF_W'(col_q >> 1);

    // Horizontal pair max of the current column pair, then fold in the
    // buffered upper-row pair for the full 2x2 window.
    assign pair_max = smax(left_q, bus.pix_in);
    assign pool_val = smax(row_buf_q[half_col], pair_max);
    assign pool_idx = IDX_W'(row_q >> 1) * IDX_W'(HALF) + IDX_W'(half_col);

    // Odd column closes a pair: upper rows park it, lower rows complete a window.
    assign rb_wr   = accept && col_q[0] && !row_q[0];
    assign pool_wr = accept && col_q[0] &&  row_q[0];

    // Raster position and the even-column holding register.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        left_d = left_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
            if (!col_q[0]) begin
                left_d = bus.pix_in;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_row_buf
            assign row_buf_d[gi] = (rb_wr && half_col == HALF_W'(gi)) ? pair_max
                                                                      : row_buf_q[gi];
        end
        for (gi = 0; gi < OUT_N; gi++) begin : g_pooled
            assign pooled_d[gi] = (pool_wr && pool_idx == IDX_W'(gi)) ? pool_val
                                                                      : pooled_q[gi];
            assign bus.pooled_img[gi] = pooled_q[gi];
        end
    endgenerate

    // Frame state: done is set by the window that completes the frame and is
    // cleared by the first pixel of the next one.
    always_comb begin
        state_d     = state_q;
        pool_done_d = pool_done_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept && last_col && last_row) begin
                    state_d     = S_DONE;
                    pool_done_d = 1'b1;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_d     = S_FILL;
                    pool_done_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                pool_done_d = 1'b0;
            end
        endcase
    end

    // Datapath and control registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            left_q      <= '0;
            state_q     <= S_IDLE;
            pool_done_q <= 1'b0;
            for (int i = 0; i < HALF; i++) begin
                row_buf_q[i] <= '0;
            end
            for (int i = 0; i < OUT_N; i++) begin
                pooled_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            left_q      <= left_d;
            state_q     <= state_d;
            pool_done_q <= pool_done_d;
            row_buf_q   <= row_buf_d;
            pooled_q    <= pooled_d;
        end
    end

    assign bus.pool_done = pool_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: a frame-level reference model (stored
// image, window maxima computed directly from the four pixels) checked every
// cycle, plus hand-computed literal expectations.
module tb_max_pool_2x2;
    localparam int IMG_W  = 28;
    localparam int DATA_W = 16;
    localparam int HALF   = IMG_W / 2;
    localparam int OUT_N  = HALF * HALF;
    localparam int FRAME  = IMG_W * IMG_W;

    logic clk = 1'b0;
    logic reset;

    max_pool_2x2_if #(.IMG_W(IMG_W), .DATA_W(DATA_W)) bus ();

    max_pool_2x2 #(.IMG_W(IMG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;
    int cyc      = 0;

    // Reference model state
    logic signed [DATA_W-1:0] img      [0:IMG_W-1][0:IMG_W-1];
    logic signed [DATA_W-1:0] exp_pool [0:OUT_N-1];
    logic                     exp_done;
    int                       pos;
    int                       mr, mc;

    assign mr = pos / IMG_W;
    assign mc = pos % IMG_W;

    function automatic logic signed [DATA_W-1:0] max2(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DATA_W-1:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return '0;
            1:       return DATA_W'(r * IMG_W + c);
            2:       return (r == 0 && c == 1) ? -16'sd1 :
                            (r == IMG_W - 1 && c == IMG_W - 2) ? -16'sd3 : -16'sd5;
            default: return 16'sd7;
        endcase
    endfunction

    // Model: store each accepted pixel; when a window's last pixel arrives,
    // its output is the max of the four stored pixels.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < OUT_N; k++) exp_pool[k] <= '0;
            for (int r = 0; r < IMG_W; r++)
                for (int c = 0; c < IMG_W; c++) img[r][c] <= '0;
            exp_done <= 1'b0;
            pos      <= 0;
        end else if (bus.enable && bus.pix_valid) begin
            img[mr][mc] <= bus.pix_in;
            if (mr % 2 == 1 && mc % 2 == 1)
                exp_pool[(mr / 2) * HALF + mc / 2] <=
                    max2(max2(img[mr-1][mc-1], img[mr-1][mc]),
                         max2(img[mr][mc-1], bus.pix_in));
            if (pos == 0)         exp_done <= 1'b0;
            if (pos == FRAME - 1) exp_done <= 1'b1;
            pos <= (pos + 1) % FRAME;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            int bad;
            n_checks++;
            if (bus.pool_done !== exp_done) begin
                n_fail++;
                $display("FAIL pool_done t=%0t: got %0b expected %0b", $time, bus.pool_done, exp_done);
            end
            n_checks++;
            bad = -1;
            for (int k = 0; k < OUT_N; k++)
                if (bad < 0 && bus.pooled_img[k] !== exp_pool[k]) bad = k;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL pooled_img[%0d] t=%0t: got %0d expected %0d",
                         bad, $time, bus.pooled_img[bad], exp_pool[bad]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    // Present one pixel; in stall mode every third cycle is a bubble.
    task automatic drive(input logic signed [DATA_W-1:0] v, input bit stall);
        @(negedge clk);
        cyc++;
        while (stall && (cyc % 3 == 0)) begin
            bus.enable    = 1'b1;
            bus.pix_valid = 1'b0;
            bus.pix_in    = 16'sh1234;
            @(negedge clk);
            cyc++;
        end
        bus.enable    = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = v;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 16'sh2222;
    endtask

    task automatic send_frame(input int kind, input bit stall, input string name);
        for (int p = 0; p < FRAME; p++) begin
            if (stall && p == 400) begin
                // Enable gap with valid held high: these pixels must be ignored.
                for (int g = 0; g < 50; g++) begin
                    @(negedge clk);
                    bus.enable    = 1'b0;
                    bus.pix_valid = 1'b1;
                    bus.pix_in    = 16'sh7fff;
                end
            end
            drive(pix_of(kind, p / IMG_W, p % IMG_W), stall);
        end
        chk({name, "_done_before_last"}, int'(bus.pool_done), 0);
        $display("frame %s sent", name);
    endtask

    task automatic chk_ramp(input string name);
        chk({name, "_model0"},   int'(exp_pool[0]), 29);
        chk({name, "_model195"}, int'(exp_pool[OUT_N-1]), 783);
        chk({name, "_out0"},     int'(bus.pooled_img[0]), 29);
        chk({name, "_out13"},    int'(bus.pooled_img[13]), 55);
        chk({name, "_out195"},   int'(bus.pooled_img[OUT_N-1]), 783);
    endtask

    initial begin
        reset         = 1'b0;
        bus.enable    = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        repeat (3) @(negedge clk);
        chk("reset_done",  int'(bus.pool_done), 0);
        chk("reset_out0",  int'(bus.pooled_img[0]), 0);
        chk("reset_out195", int'(bus.pooled_img[OUT_N-1]), 0);
        reset  = 1'b1;
        chk_on = 1'b1;

        // All-zero frame
        send_frame(0, 1'b0, "zero");
        idle_cycle();
        chk("zero_done", int'(bus.pool_done), 1);
        chk("zero_out100", int'(bus.pooled_img[100]), 0);

        // Ramp frame
        send_frame(1, 1'b0, "ramp");
        idle_cycle();
        chk("ramp_done", int'(bus.pool_done), 1);
        chk_ramp("ramp");

        // Negative values
        send_frame(2, 1'b0, "neg");
        idle_cycle();
        chk("neg_done",   int'(bus.pool_done), 1);
        chk("neg_out0",   int'(bus.pooled_img[0]), -1);
        chk("neg_out1",   int'(bus.pooled_img[1]), -5);
        chk("neg_out194", int'(bus.pooled_img[OUT_N-2]), -5);
        chk("neg_out195", int'(bus.pooled_img[OUT_N-1]), -3);

        // Ramp with bubbles and an enable gap
        send_frame(1, 1'b1, "stall");
        idle_cycle();
        chk("stall_done", int'(bus.pool_done), 1);
        chk_ramp("stall");

        // Reset after 300 accepts: outputs clear without a clock edge
        for (int p = 0; p < 300; p++) drive(pix_of(1, p / IMG_W, p % IMG_W), 1'b0);
        idle_cycle();
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_done",   int'(bus.pool_done), 0);
        chk("rst_mid_out0",   int'(bus.pooled_img[0]), 0);
        chk("rst_mid_out195", int'(bus.pooled_img[OUT_N-1]), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        send_frame(1, 1'b0, "post_rst");
        idle_cycle();
        chk("post_rst_done", int'(bus.pool_done), 1);
        chk_ramp("post_rst");

        // Back-to-back: ramp then all-7 with no gap
        send_frame(1, 1'b0, "b2b_ramp");
        for (int p = 0; p < FRAME; p++) begin
            drive(16'sd7, 1'b0);
            if (p == 0)  chk("b2b_done_held", int'(bus.pool_done), 1);
            if (p == 1)  chk("b2b_done_fell", int'(bus.pool_done), 0);
            if (p == 29) chk("b2b_out0_old",  int'(bus.pooled_img[0]), 29);
            if (p == 30) chk("b2b_out0_new",  int'(bus.pooled_img[0]), 7);
        end
        chk("b2b_done_before_last", int'(bus.pool_done), 0);
        idle_cycle();
        chk("b2b_done",   int'(bus.pool_done), 1);
        chk("b2b_out0",   int'(bus.pooled_img[0]), 7);
        chk("b2b_out195", int'(bus.pooled_img[OUT_N-1]), 7);

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
